// File: rtl/peripheral_uart_rx_frontend.sv
`default_nettype none
// ============================================================================
//  Module   : peripheral_uart_rx_frontend
//  Brief    : UART 8N1 receive front-end. Synchronises the serial input,
//             oversamples it on a prescaled SMCLK tick, deframes characters
//             and presents each byte on a valid/ready handshake. Framing
//             errors and overruns are reported as single-cycle pulses.
//  Revision : 1.0 - initial release
// ============================================================================
module peripheral_uart_rx_frontend #(
   parameter int OVERSAMPLE = 16,
   parameter int DIV_WIDTH  = 16
) (
   input  logic                 mclk,
   input  logic                 puc_rst,
   input  logic                 smclk_en,
   input  logic [DIV_WIDTH-1:0] baud_div,
   input  logic                 uart_rxd,
   output logic [7:0]           rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 rx_frame_err,
   output logic                 rx_overrun,
   output logic                 rx_busy
);

   // Sample counter geometry. Sample points are named by the counter value
   // reached on the tick, so tick k after the start edge is at position k.
   localparam int SW  = $clog2(OVERSAMPLE);
   localparam int MID = OVERSAMPLE / 2;

   localparam logic [SW-1:0] S_FIRST = SW'(MID - 1);
   localparam logic [SW-1:0] S_MID   = SW'(MID);
   localparam logic [SW-1:0] S_LAST  = SW'(MID + 1);
   localparam logic [SW-1:0] S_WRAP  = SW'(OVERSAMPLE - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } state_t;

   // Input synchroniser and edge history
   logic                 sync1;
   logic                 rxd_s;
   logic                 rxd_prev;

   // Prescaler and oversampling
   logic [DIV_WIDTH-1:0] presc;
   logic [DIV_WIDTH-1:0] div_lat;
   logic                 tick;
   logic [SW-1:0]        samp_cnt;
   logic [SW-1:0]        samp_nxt;
   logic                 smp_a;
   logic                 smp_b;
   logic                 bit_val;
   logic                 decide;

   // Deframer
   state_t               state;
   logic [2:0]           bit_cnt;
   logic [7:0]           shreg;
   logic                 start_edge;

   // Two-flop synchroniser plus one delayed copy for falling-edge detection
   always_ff @(posedge mclk or posedge puc_rst) begin
      if (puc_rst) begin
         sync1    <= 1'b1;
         rxd_s    <= 1'b1;
         rxd_prev <= 1'b1;
      end else begin
         sync1    <= uart_rxd;
         rxd_s    <= sync1;
         rxd_prev <= rxd_s;
      end
   end

   // Tick generation, sample position and majority vote of the three samples
   always_comb begin
      tick       = smclk_en && (presc == div_lat);
      samp_nxt   = (samp_cnt == S_WRAP) ? '0 : samp_cnt + 1'b1;
      decide     = tick && (samp_nxt == S_LAST);
      bit_val    = (smp_a & smp_b) | (smp_a & rxd_s) | (smp_b & rxd_s);
      start_edge = (state == ST_IDLE) && rxd_prev && !rxd_s;
   end

   // Free-running prescaler; the divider is latched only on a wrap so a
   // baud_div change never truncates a tick period. A start edge restarts
   // both the prescaler and the sample counter to centre bit timing on it.
   always_ff @(posedge mclk or posedge puc_rst) begin
      if (puc_rst) begin
         presc    <= '0;
         div_lat  <= '0;
         samp_cnt <= '0;
         smp_a    <= 1'b1;
         smp_b    <= 1'b1;
      end else if (start_edge) begin
         presc    <= '0;
         div_lat  <= baud_div;
         samp_cnt <= '0;
      end else if (tick) begin
         presc    <= '0;
         div_lat  <= baud_div;
         samp_cnt <= samp_nxt;
         if (samp_nxt == S_FIRST) begin
            smp_a <= rxd_s;
         end
         if (samp_nxt == S_MID) begin
            smp_b <= rxd_s;
         end
      end else if (smclk_en) begin
         presc    <= presc + 1'b1;
      end
   end

   // Deframing FSM with registered status and handshake outputs
   always_ff @(posedge mclk or posedge puc_rst) begin
      if (puc_rst) begin
         state        <= ST_IDLE;
         bit_cnt      <= '0;
         shreg        <= '0;
         rx_data      <= '0;
         rx_valid     <= 1'b0;
         rx_frame_err <= 1'b0;
         rx_overrun   <= 1'b0;
         rx_busy      <= 1'b0;
      end else begin
         rx_frame_err <= 1'b0;
         rx_overrun   <= 1'b0;

         // Consumer acceptance; a byte loaded below in the same cycle wins
         if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end

         case (state)
            ST_IDLE: begin
               if (start_edge) begin
                  state   <= ST_START;
                  rx_busy <= 1'b1;
               end
            end

            ST_START: begin
               if (decide) begin
                  if (bit_val) begin
                     // Low pulse shorter than half a bit: treat as noise
                     state   <= ST_IDLE;
                     rx_busy <= 1'b0;
                  end else begin
                     state   <= ST_DATA;
                     bit_cnt <= '0;
                  end
               end
            end

            ST_DATA: begin
               if (decide) begin
                  shreg   <= {bit_val, shreg[7:1]};
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == 3'd7) begin
                     state <= ST_STOP;
                  end
               end
            end

            ST_STOP: begin
               // Leave at mid-stop so the next start edge can be caught early
               if (decide) begin
                  state   <= ST_IDLE;
                  rx_busy <= 1'b0;
                  if (!bit_val) begin
                     rx_frame_err <= 1'b1;
                  end else if (!rx_valid || rx_ready) begin
                     rx_data  <= shreg;
                     rx_valid <= 1'b1;
                  end else begin
                     rx_overrun <= 1'b1;
                  end
               end
            end

            default: begin
               state   <= ST_IDLE;
               rx_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_peripheral_uart_rx_frontend.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_peripheral_uart_rx_frontend
//  Brief    : Self-checking bench for the UART receive front-end.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_peripheral_uart_rx_frontend;

   localparam int OS = 16;

   logic        mclk = 1'b0;
   logic        puc_rst;
   logic        smclk_en;
   logic [15:0] baud_div;
   logic        uart_rxd;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        rx_frame_err;
   logic        rx_overrun;
   logic        rx_busy;

   int tests = 0;
   int fails = 0;
   bit half_rate = 1'b0;

   // Observed events: 0..255 accepted byte, 256 framing error, 257 overrun
   int ev_q[$];
   int exp_q[$];

   localparam int EV_FERR = 256;
   localparam int EV_OVR  = 257;

   typedef struct {
      logic [7:0]  data;
      logic        stop;
      logic [15:0] div;
      logic        half;
      int          exp_ev;
   } vec_t;

   peripheral_uart_rx_frontend #(
      .OVERSAMPLE(OS),
      .DIV_WIDTH (16)
   ) dut (
      .mclk        (mclk),
      .puc_rst     (puc_rst),
      .smclk_en    (smclk_en),
      .baud_div    (baud_div),
      .uart_rxd    (uart_rxd),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rx_ready    (rx_ready),
      .rx_frame_err(rx_frame_err),
      .rx_overrun  (rx_overrun),
      .rx_busy     (rx_busy)
   );

   always #5 mclk = ~mclk;

   // SMCLK enable: every cycle, or every other cycle in half-rate mode
   initial begin
      smclk_en = 1'b1;
      forever begin
         @(posedge mclk);
         #1;
         smclk_en = half_rate ? ~smclk_en : 1'b1;
      end
   end

   // Event monitor, sampled away from the active edge
   always @(negedge mclk) begin
      if (!puc_rst) begin
         if (rx_valid && rx_ready) ev_q.push_back(int'(rx_data));
         if (rx_frame_err)         ev_q.push_back(EV_FERR);
         if (rx_overrun)           ev_q.push_back(EV_OVR);
      end
   end

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic int bit_cycles();
      return (int'(baud_div) + 1) * OS * (half_rate ? 2 : 1);
   endfunction

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge mclk);
      #1;
   endtask

   task automatic send_bit(input logic v);
      uart_rxd = v;
      wait_cycles(bit_cycles());
   endtask

   // Full 8N1 frame; a bad stop bit is followed by one idle bit so the next
   // frame has a clean falling edge
   task automatic send_frame(input logic [7:0] d, input logic stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit(stop);
      if (!stop) send_bit(1'b1);
   endtask

   task automatic set_rate(input logic [15:0] div, input logic half);
      baud_div  = div;
      half_rate = half;
      uart_rxd  = 1'b1;
      wait_cycles(3 * bit_cycles());
   endtask

   function automatic int head_or_none();
      return (ev_q.size() >= 1) ? ev_q[0] : -1;
   endfunction

   task automatic check_reset_outputs(input string tag);
      check({tag, "_data"},  32'(rx_data),      32'h0);
      check({tag, "_valid"}, 32'(rx_valid),     32'h0);
      check({tag, "_ferr"},  32'(rx_frame_err), 32'h0);
      check({tag, "_ovr"},   32'(rx_overrun),   32'h0);
      check({tag, "_busy"},  32'(rx_busy),      32'h0);
   endtask

   initial begin
      vec_t tbl[7];
      int   lat;
      logic [7:0] d;
      logic       st;

      tbl[0] = '{8'h00, 1'b1, 16'd3, 1'b1, 8'h00};
      tbl[1] = '{8'hFF, 1'b1, 16'd3, 1'b1, 8'hFF};
      tbl[2] = '{8'h3C, 1'b1, 16'd3, 1'b1, 8'h3C};
      tbl[3] = '{8'h55, 1'b0, 16'd0, 1'b0, EV_FERR};
      tbl[4] = '{8'hA5, 1'b1, 16'd0, 1'b0, 8'hA5};
      tbl[5] = '{8'h81, 1'b1, 16'd1, 1'b0, 8'h81};
      tbl[6] = '{8'h7E, 1'b1, 16'd2, 1'b1, 8'h7E};

      puc_rst  = 1'b1;
      uart_rxd = 1'b1;
      rx_ready = 1'b1;
      baud_div = 16'd0;
      wait_cycles(5);
      check_reset_outputs("reset");
      puc_rst = 1'b0;
      wait_cycles(20);

      // Single frame at 16 cycles/bit with exact output latency
      fork
         send_frame(8'hA5, 1'b1);
         begin
            lat = 0;
            do begin
               @(posedge mclk);
               #1;
               lat++;
            end while (!rx_valid && lat < 400);
            // 2 sync stages + 1 edge-detect cycle + 153 ticks
            check("t1_latency", 32'(lat), 32'd156);
            check("t1_data", 32'(rx_data), 32'hA5);
            check("t1_ferr", 32'(rx_frame_err), 32'h0);
            wait_cycles(1);
            check("t1_valid_one_cycle", 32'(rx_valid), 32'h0);
         end
      join
      wait_cycles(2 * bit_cycles());
      check("t1_events", 32'(ev_q.size()), 32'd1);
      check("t1_event0", 32'(head_or_none()), 32'hA5);
      ev_q.delete();

      // Table-driven frames; consecutive entries with the same rate are sent
      // back-to-back
      for (int i = 0; i < 7; i++) begin
         if (tbl[i].div != baud_div || tbl[i].half != half_rate)
            set_rate(tbl[i].div, tbl[i].half);
         send_frame(tbl[i].data, tbl[i].stop);
         check($sformatf("tbl%0d_count", i), 32'(ev_q.size()), 32'd1);
         check($sformatf("tbl%0d_event", i), 32'(head_or_none()), 32'(tbl[i].exp_ev));
         if (!tbl[i].stop) check($sformatf("tbl%0d_valid", i), 32'(rx_valid), 32'h0);
         ev_q.delete();
      end

      // Short low glitch while idle is rejected
      set_rate(16'd0, 1'b0);
      uart_rxd = 1'b0;
      wait_cycles(4);
      uart_rxd = 1'b1;
      wait_cycles(3);
      check("t3_busy_during", 32'(rx_busy), 32'h1);
      wait_cycles(40);
      check("t3_busy_after", 32'(rx_busy), 32'h0);
      check("t3_valid", 32'(rx_valid), 32'h0);
      check("t3_events", 32'(ev_q.size()), 32'd0);
      ev_q.delete();

      // Overrun while the consumer stalls, then late acceptance
      rx_ready = 1'b0;
      send_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1);
      check("t5_events", 32'(ev_q.size()), 32'd1);
      check("t5_overrun", 32'(head_or_none()), 32'(EV_OVR));
      check("t5_valid_held", 32'(rx_valid), 32'h1);
      check("t5_data_held", 32'(rx_data), 32'h11);
      ev_q.delete();
      rx_ready = 1'b1;
      wait_cycles(1);
      check("t5_valid_cleared", 32'(rx_valid), 32'h0);
      check("t5_accept_count", 32'(ev_q.size()), 32'd1);
      check("t5_accept_data", 32'(head_or_none()), 32'h11);
      ev_q.delete();

      // Reset in the middle of a frame, then recovery
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      check("t6_busy_pre", 32'(rx_busy), 32'h1);
      puc_rst = 1'b1;
      #1;
      check_reset_outputs("t6_rst");
      wait_cycles(3);
      uart_rxd = 1'b1;
      puc_rst  = 1'b0;
      wait_cycles(3 * bit_cycles());
      ev_q.delete();
      send_frame(8'h7E, 1'b1);
      check("t6_events", 32'(ev_q.size()), 32'd1);
      check("t6_data", 32'(head_or_none()), 32'h7E);
      ev_q.delete();

      // Randomised frames against a frame-level reference model
      exp_q.delete();
      for (int n = 0; n < 12; n++) begin
         set_rate(16'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
         d  = 8'($urandom);
         st = ($urandom_range(0, 4) != 0);
         exp_q.push_back(st ? int'(d) : EV_FERR);
         send_frame(d, st);
      end
      wait_cycles(2 * bit_cycles());
      check("rand_count", 32'(ev_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         check($sformatf("rand_ev%0d", i),
               (i < ev_q.size()) ? 32'(ev_q[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
